store_write_buffer: RTL and testbench



---
 rtl/store_write_buffer_if.sv | 41 ++++
 rtl/store_write_buffer.sv | 158 +++++++++++++++
 tb/tb_store_write_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
//------------------------------------------------------------------------------
// store_write_buffer_if
// Bundles the store-side handshake, the data-memory write port and the load
// hazard probe of the store write buffer.
//   slave  modport : the buffer itself (takes stores, drives the memory port)
//   master modport : the surrounding pipeline / memory system
// Signals:
//   st_valid/st_ready/st_addr/st_sel/st_data : store request from MEM stage
//   mem_req/mem_addr/mem_wstrb/mem_wdata/mem_ack : head entry to memory
//   ld_addr/ld_hit : load word-address hazard probe
//   empty : no valid entries
//------------------------------------------------------------------------------
`default_nettype none

interface store_write_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [2:0]  st_sel;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        empty;

  modport slave (
    input  st_valid, st_addr, st_sel, st_data, mem_ack, ld_addr,
    output st_ready, mem_req, mem_addr, mem_wstrb, mem_wdata, ld_hit, empty
  );

  modport master (
    output st_valid, st_addr, st_sel, st_data, mem_ack, ld_addr,
    input  st_ready, mem_req, mem_addr, mem_wstrb, mem_wdata, ld_hit, empty
  );
endinterface

`default_nettype wire

// File: rtl/store_write_buffer.sv
//------------------------------------------------------------------------------
// store_write_buffer
// In-order store FIFO between the MEM-stage store shifter and the data-memory
// write port. Builds per-byte strobes from the store type and address lane,
// queues up to DEPTH stores, drains the head over mem_req/mem_ack and flags
// loads whose word address matches a pending or incoming store.
//
// Ports:
//   clk    : system clock
//   resetn : synchronous active-low reset
//   sbif   : store_write_buffer_if.slave (store handshake, memory port,
//            load hazard probe, empty flag)
//
// Parameters:
//   DEPTH : number of entries (power of two, >= 2)
//   PTR_W : log2(DEPTH)
//
// Build option:
//   STORE_MERGE_EN : when defined, a store to the same word as the tail entry
//                    merges into it (only when the tail is not the head on the
//                    bus); merging is allowed even when the buffer is full.
//------------------------------------------------------------------------------
`default_nettype none

module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  store_write_buffer_if.slave   sbif
);

  localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);

  // Byte strobes from store type and lane index; unsupported types write nothing.
  function automatic logic [3:0] f_wstrb(input logic [2:0] sel, input logic [1:0] b);
    logic [3:0] strb;
    case (sel)
      3'd0:    strb = 4'b0001 << b;
      3'd1:    strb = b[1] ? 4'b1100 : 4'b0011;
      3'd2:    strb = 4'b1111;
      3'd3:    strb = 4'b1111 >> (2'd3 - b);   // SWL: lanes 0..b
      3'd4:    strb = 4'b1111 << b;            // SWR: lanes b..3
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Entry storage; contents are don't-care until written.
  logic [29:0]      r_addr [DEPTH];
  logic [3:0]       r_strb [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_sel_ok;
  logic [3:0]       w_wstrb;
  logic             w_merge_ok;
  logic             w_ready;
  logic             w_push;
  logic             w_write;
  logic             w_alloc;
  logic             w_pop;
  logic             w_hit;
  logic             w_unused;

  assign w_sel_ok = (sbif.st_sel <= 3'd4);
  assign w_wstrb  = f_wstrb(sbif.st_sel, sbif.st_addr[1:0]);

`ifdef STORE_MERGE_EN
  logic [PTR_W-1:0] w_tail_last;
  logic             w_merge;

  assign w_tail_last = r_tail - PTR_W'(1);
  // With two or more entries the tail cannot be the head being presented,
  // so rewriting it never disturbs the bus.
  assign w_merge_ok  = w_sel_ok && (r_count >= (PTR_W+1)'(2)) &&
                       (r_addr[w_tail_last] == sbif.st_addr[31:2]);
  assign w_ready     = (r_count != LP_FULL) || w_merge_ok;
  assign w_merge     = w_write && w_merge_ok;
`else
  assign w_merge_ok  = 1'b0;
  assign w_ready     = (r_count != LP_FULL);
`endif

  assign w_push  = sbif.st_valid && w_ready;
  assign w_write = w_push && w_sel_ok;
  assign w_alloc = w_write && !w_merge_ok;
  assign w_pop   = sbif.mem_ack && (r_count != (PTR_W+1)'(0));

  // Pointer and occupancy bookkeeping with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload writes: allocate at the tail, or merge into the last entry.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= sbif.st_addr[31:2];
      r_strb[r_tail] <= w_wstrb;
      r_data[r_tail] <= sbif.st_data;
    end
`ifdef STORE_MERGE_EN
    else if (w_merge) begin
      r_strb[w_tail_last] <= r_strb[w_tail_last] | w_wstrb;
      for (int k = 0; k < 4; k++) begin
        if (w_wstrb[k]) begin
          r_data[w_tail_last][8*k +: 8] <= sbif.st_data[8*k +: 8];
        end
      end
    end
`endif
  end

  // Load hazard: any valid entry (offset from head below count) or the
  // store being written this cycle that hits the load's word.
  always_comb begin
    logic [PTR_W-1:0] off;
    w_hit = w_write && (sbif.st_addr[31:2] == sbif.ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      off   = PTR_W'(i) - r_head;
      w_hit = w_hit | (({1'b0, off} < r_count) && (r_addr[i] == sbif.ld_addr[31:2]));
    end
  end

  assign sbif.st_ready  = w_ready;
  assign sbif.mem_req   = (r_count != (PTR_W+1)'(0));
  assign sbif.mem_addr  = {r_addr[r_head], 2'b00};
  assign sbif.mem_wstrb = r_strb[r_head];
  assign sbif.mem_wdata = r_data[r_head];
  assign sbif.ld_hit    = w_hit;
  assign sbif.empty     = (r_count == (PTR_W+1)'(0));

  // Load byte offset is irrelevant to word-granular hazard detection.
  assign w_unused = &{1'b0, sbif.ld_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none

module tb_store_write_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  store_write_buffer_if sbif ();

  store_write_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sbif   (sbif.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [29:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } ent_t;

  // Strobe rule from the store type table, written arithmetically.
  function automatic logic [3:0] mdl_strb(input logic [2:0] sel, input int b);
    int m;
    case (sel)
      3'd0:    m = 1 << b;
      3'd1:    m = (b < 2) ? 3 : 12;
      3'd2:    m = 15;
      3'd3:    m = (1 << (b + 1)) - 1;
      3'd4:    m = (15 << b) & 15;
      default: m = 0;
    endcase
    return m[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    sbif.st_valid = v;
    sbif.st_addr  = a;
    sbif.st_sel   = s;
    sbif.st_data  = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    sbif.mem_ack = 1'b0;
    sbif.ld_addr = 32'hFFFF_FFF0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (sbif.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", sbif.mem_req); else n_pass++;
    n_total++; if (sbif.empty !== 1'b1) $display("FAIL reset_empty got %b want 1", sbif.empty); else n_pass++;
    n_total++; if (sbif.st_ready !== 1'b1) $display("FAIL reset_st_ready got %b want 1", sbif.st_ready); else n_pass++;
    n_total++; if (sbif.ld_hit !== 1'b0) $display("FAIL reset_ld_hit got %b want 0", sbif.ld_hit); else n_pass++;
  endtask

  task automatic test_sb_basic();
    do_reset();
    drive(1'b1, 32'h0000_1003, 3'd0, 32'hAB00_0000);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_total++; if (sbif.mem_req !== 1'b1) $display("FAIL sb_mem_req got %b want 1", sbif.mem_req); else n_pass++;
    n_total++; if (sbif.mem_addr !== 32'h0000_1000) $display("FAIL sb_mem_addr got %h want 00001000", sbif.mem_addr); else n_pass++;
    n_total++; if (sbif.mem_wstrb !== 4'b1000) $display("FAIL sb_wstrb got %b want 1000", sbif.mem_wstrb); else n_pass++;
    n_total++; if (sbif.mem_wdata !== 32'hAB00_0000) $display("FAIL sb_wdata got %h want ab000000", sbif.mem_wdata); else n_pass++;
    sbif.mem_ack = 1'b1;
    tick();
    sbif.mem_ack = 1'b0;
    n_total++; if (sbif.empty !== 1'b1) $display("FAIL sb_empty_after_ack got %b want 1", sbif.empty); else n_pass++;
    n_total++; if (sbif.mem_req !== 1'b0) $display("FAIL sb_req_after_ack got %b want 0", sbif.mem_req); else n_pass++;
  endtask

  task automatic test_swl_swr();
    do_reset();
    drive(1'b1, 32'h0000_2000, 3'd3, 32'h1122_3344);
    tick();
    drive(1'b1, 32'h0000_2005, 3'd4, 32'h5566_7700);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    tick();
    n_total++; if (sbif.mem_addr !== 32'h0000_2000) $display("FAIL swl_addr got %h want 00002000", sbif.mem_addr); else n_pass++;
    n_total++; if (sbif.mem_wstrb !== 4'b0001) $display("FAIL swl_wstrb got %b want 0001", sbif.mem_wstrb); else n_pass++;
    sbif.mem_ack = 1'b1;
    tick();
    sbif.mem_ack = 1'b0;
    n_total++; if (sbif.mem_addr !== 32'h0000_2004) $display("FAIL swr_addr got %h want 00002004", sbif.mem_addr); else n_pass++;
    n_total++; if (sbif.mem_wstrb !== 4'b1110) $display("FAIL swr_wstrb got %b want 1110", sbif.mem_wstrb); else n_pass++;
    n_total++; if (sbif.mem_wdata !== 32'h5566_7700) $display("FAIL swr_wdata got %h want 55667700", sbif.mem_wdata); else n_pass++;
    sbif.mem_ack = 1'b1;
    tick();
    sbif.mem_ack = 1'b0;
    n_total++; if (sbif.empty !== 1'b1) $display("FAIL swlr_drained got %b want 1", sbif.empty); else n_pass++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 3'd2, 32'hA0 + 32'(i));
      tick();
    end
    drive(1'b1, 32'h0000_0200, 3'd2, 32'hDEAD_BEEF);
    n_total++; if (sbif.st_ready !== 1'b0) $display("FAIL full_st_ready got %b want 0", sbif.st_ready); else n_pass++;
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_total++; if (sbif.mem_addr !== 32'h100) $display("FAIL full_head got %h want 00000100", sbif.mem_addr); else n_pass++;
    sbif.mem_ack = 1'b1;
    tick();
    sbif.mem_ack = 1'b0;
    n_total++; if (sbif.st_ready !== 1'b1) $display("FAIL after_pop_st_ready got %b want 1", sbif.st_ready); else n_pass++;
    // four simultaneous push/pop cycles: heads 1..4 leave, stores 4..7 enter
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4*(i+4)), 3'd2, 32'hA0 + 32'(i+4));
      sbif.mem_ack = 1'b1;
      n_total++;
      if (sbif.mem_wdata !== 32'hA0 + 32'(i+1)) $display("FAIL pair_head%0d got %h want %h", i, sbif.mem_wdata, 32'hA0 + 32'(i+1)); else n_pass++;
      tick();
    end
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    for (int i = 5; i < 8; i++) begin
      n_total++;
      if (sbif.mem_addr !== 32'h100 + 32'(4*i) || sbif.mem_wdata !== 32'hA0 + 32'(i))
        $display("FAIL drain_order%0d got %h/%h want %h/%h", i, sbif.mem_addr, sbif.mem_wdata, 32'h100 + 32'(4*i), 32'hA0 + 32'(i));
      else n_pass++;
      tick();
    end
    sbif.mem_ack = 1'b0;
    n_total++; if (sbif.empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", sbif.empty); else n_pass++;
  endtask

  task automatic test_ld_hit();
    do_reset();
    drive(1'b1, 32'h0000_3000, 3'd2, 32'h1234_5678);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    sbif.ld_addr = 32'h0000_3002;
    #1;
    n_total++; if (sbif.ld_hit !== 1'b1) $display("FAIL ld_hit_same_word got %b want 1", sbif.ld_hit); else n_pass++;
    sbif.ld_addr = 32'h0000_3004;
    #1;
    n_total++; if (sbif.ld_hit !== 1'b0) $display("FAIL ld_hit_next_word got %b want 0", sbif.ld_hit); else n_pass++;
    drive(1'b1, 32'h0000_4002, 3'd1, 32'hBEEF_0000);
    sbif.ld_addr = 32'h0000_4000;
    #1;
    n_total++; if (sbif.ld_hit !== 1'b1) $display("FAIL ld_hit_incoming got %b want 1", sbif.ld_hit); else n_pass++;
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    sbif.mem_ack = 1'b1;
    tick();
    n_total++; if (sbif.mem_wstrb !== 4'b1100) $display("FAIL sh_hi_wstrb got %b want 1100", sbif.mem_wstrb); else n_pass++;
    tick();
    sbif.mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(4*i), 3'd2, 32'(i));
      tick();
    end
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_total++; if (sbif.mem_req !== 1'b1) $display("FAIL pre_reset_req got %b want 1", sbif.mem_req); else n_pass++;
    resetn = 1'b0;
    tick();
    n_total++; if (sbif.mem_req !== 1'b0) $display("FAIL midreset_req got %b want 0", sbif.mem_req); else n_pass++;
    n_total++; if (sbif.empty !== 1'b1) $display("FAIL midreset_empty got %b want 1", sbif.empty); else n_pass++;
    n_total++; if (sbif.st_ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", sbif.st_ready); else n_pass++;
    resetn = 1'b1;
  endtask

`ifdef STORE_MERGE_EN
  task automatic test_merge();
    do_reset();
    drive(1'b1, 32'h0000_5000, 3'd2, 32'hCAFE_F00D);
    tick();
    drive(1'b1, 32'h0000_6000, 3'd0, 32'h0000_0011);
    tick();
    drive(1'b1, 32'h0000_6001, 3'd0, 32'h0000_2200);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    sbif.mem_ack = 1'b1;
    tick();
    n_total++; if (sbif.mem_wstrb !== 4'b0011) $display("FAIL merge_wstrb got %b want 0011", sbif.mem_wstrb); else n_pass++;
    n_total++; if (sbif.mem_wdata[15:0] !== 16'h2211) $display("FAIL merge_data got %h want 2211", sbif.mem_wdata[15:0]); else n_pass++;
    tick();
    sbif.mem_ack = 1'b0;
    n_total++; if (sbif.empty !== 1'b1) $display("FAIL merge_count got empty=%b want 1", sbif.empty); else n_pass++;
  endtask
`endif

  // Random traffic against a queue-based reference model.
  task automatic test_random();
    ent_t q[$];
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic v, ack, sel_ok, exp_ready, exp_hit, merge;
      logic [31:0] a, d, la;
      logic [2:0] s;
      logic [3:0] ns;
      int sz;
      v   = ($urandom_range(0, 99) < 60);
      a   = 32'($urandom_range(0, 31));
      s   = 3'($urandom_range(0, 7));
      d   = $urandom;
      ack = ($urandom_range(0, 99) < 45);
      la  = 32'($urandom_range(0, 31));
      drive(v, a, s, d);
      sbif.mem_ack = ack;
      sbif.ld_addr = la;
      #1;
      sz     = q.size();
      sel_ok = (s <= 3'd4);
      ns     = mdl_strb(s, int'(a[1:0]));
`ifdef STORE_MERGE_EN
      merge = sel_ok && (sz >= 2) && (q[sz-1].a == a[31:2]);
`else
      merge = 1'b0;
`endif
      exp_ready = (sz != DEPTH) || merge;
      exp_hit   = v && exp_ready && sel_ok && (a[31:2] == la[31:2]);
      foreach (q[k]) if (q[k].a == la[31:2]) exp_hit = 1'b1;
      n_total++; if (sbif.st_ready !== exp_ready) $display("FAIL rnd_ready c%0d got %b want %b", cyc, sbif.st_ready, exp_ready); else n_pass++;
      n_total++; if (sbif.mem_req !== (sz != 0)) $display("FAIL rnd_req c%0d got %b want %b", cyc, sbif.mem_req, sz != 0); else n_pass++;
      n_total++; if (sbif.empty !== (sz == 0)) $display("FAIL rnd_empty c%0d got %b want %b", cyc, sbif.empty, sz == 0); else n_pass++;
      n_total++; if (sbif.ld_hit !== exp_hit) $display("FAIL rnd_ld_hit c%0d got %b want %b", cyc, sbif.ld_hit, exp_hit); else n_pass++;
      if (sz != 0) begin
        n_total++;
        if (sbif.mem_addr !== {q[0].a, 2'b00} || sbif.mem_wstrb !== q[0].s || sbif.mem_wdata !== q[0].d)
          $display("FAIL rnd_head c%0d got %h/%b/%h want %h/%b/%h", cyc, sbif.mem_addr, sbif.mem_wstrb,
                   sbif.mem_wdata, {q[0].a, 2'b00}, q[0].s, q[0].d);
        else n_pass++;
      end
      @(posedge clk);
      if (v && exp_ready && sel_ok && merge) begin
        q[sz-1].s = q[sz-1].s | ns;
        for (int k = 0; k < 4; k++) if (ns[k]) q[sz-1].d[8*k +: 8] = d[8*k +: 8];
      end
      if (ack && sz != 0) void'(q.pop_front());
      if (v && exp_ready && sel_ok && !merge) q.push_back('{a: a[31:2], s: ns, d: d});
      #1;
    end
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    sbif.mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sb_basic();
    test_swl_swr();
    test_full_wrap();
    test_ld_hit();
    test_reset_mid();
`ifdef STORE_MERGE_EN
    test_merge();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
